// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions for the condition-code sequencer: opcodes, sequencer
// state encoding, NZP bit positions and the branch-enable helper.
package lc3_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam int NZP_N = 2;
  localparam int NZP_Z = 1;
  localparam int NZP_P = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_WB = 2'd1,
    ST_EVAL    = 2'd2
  } seq_state_t;

  // A branch is taken when any requested condition matches the current codes.
  function automatic logic branch_taken(input logic [2:0] mask, input logic [2:0] nzp);
    return |(mask & nzp);
  endfunction

endpackage

// File: rtl/lc3_cc_sequencer_if.sv
// Handshake and condition-code bus between control store, sequencer and NZP register.
interface lc3_cc_sequencer_if;
  logic        i_Instr_Valid;
  logic        o_Instr_Ready;
  logic [15:0] i_IR;
  logic        i_WB_Done;
  logic [2:0]  i_NZP;
  logic        o_LD_CC;
  logic        o_BEN;
  logic        o_BEN_Valid;
  logic        o_CC_Pending;
  logic        o_Timeout_Err;

  modport master (
    output i_Instr_Valid, i_IR, i_WB_Done, i_NZP,
    input  o_Instr_Ready, o_LD_CC, o_BEN, o_BEN_Valid, o_CC_Pending, o_Timeout_Err
  );

  modport slave (
    input  i_Instr_Valid, i_IR, i_WB_Done, i_NZP,
    output o_Instr_Ready, o_LD_CC, o_BEN, o_BEN_Valid, o_CC_Pending, o_Timeout_Err
  );
endinterface

// File: rtl/lc3_cc_decode.sv
// Opcode classifier for the CC sequencer. Macro LC3_CC_LEA_EN makes LEA
// CC-setting (original ISA); without it LEA is a no-action opcode.
module lc3_cc_decode
  import lc3_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_cc_set,
  output logic       is_br
);

  // Classify the opcode into CC-setting, branch or no-action.
  always_comb begin
    is_cc_set = 1'b0;
    is_br     = 1'b0;
    case (opcode)
      OP_ADD, OP_AND, OP_NOT, OP_LD, OP_LDI, OP_LDR: is_cc_set = 1'b1;
`ifdef LC3_CC_LEA_EN
      OP_LEA: is_cc_set = 1'b1;
`else
      OP_LEA: is_cc_set = 1'b0;
`endif
      OP_BR:   is_br = 1'b1;
      default: is_cc_set = 1'b0;
    endcase
  end

endmodule

// File: rtl/lc3_cc_sequencer.sv
// LC-3 condition-code sequencer: pulses NZP load on writeback of CC-setting
// instructions and evaluates BR branch-enable. LEA handling via LC3_CC_LEA_EN.
module lc3_cc_sequencer
  import lc3_pkg::*;
#(
  parameter int P_WB_TIMEOUT = 15
) (
  input logic               i_CLK,
  input logic               i_RST,
  lc3_cc_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(P_WB_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(P_WB_TIMEOUT);

  seq_state_t       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       mask_r;
  logic             ben_r, ben_valid_r, err_r;
  logic             is_cc_set_s, is_br_s;
  logic             ld_cc_s, cnt_clr_s, cnt_inc_s, err_set_s, mask_ld_s, eval_s;
  logic             unused_ir_s;

  assign unused_ir_s = ^bus.i_IR[8:0];

  lc3_cc_decode u_decode (
    .opcode   (bus.i_IR[15:12]),
    .is_cc_set(is_cc_set_s),
    .is_br    (is_br_s)
  );

  // Next-state and per-cycle control decisions.
  always_comb begin
    state_nxt_s = state_r;
    ld_cc_s     = 1'b0;
    cnt_clr_s   = 1'b0;
    cnt_inc_s   = 1'b0;
    err_set_s   = 1'b0;
    mask_ld_s   = 1'b0;
    eval_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_Instr_Valid) begin
          mask_ld_s = 1'b1;
          if (is_cc_set_s) begin
            state_nxt_s = ST_WAIT_WB;
            cnt_clr_s   = 1'b1;
          end else if (is_br_s) begin
            state_nxt_s = ST_EVAL;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_WB: begin
        // A writeback in the final waiting cycle still wins over the timeout.
        if (bus.i_WB_Done) begin
          ld_cc_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == CNT_MAX) begin
          err_set_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_inc_s   = 1'b1;
          state_nxt_s = ST_WAIT_WB;
        end
      end
      ST_EVAL: begin
        eval_s      = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, counter, latched mask and registered result flags.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      mask_r      <= 3'b000;
      ben_r       <= 1'b0;
      ben_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      ben_valid_r <= eval_s;
      if (cnt_clr_s) begin
        cnt_r <= '0;
      end else if (cnt_inc_s && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (mask_ld_s) begin
        mask_r <= bus.i_IR[11:9];
      end
      if (eval_s) begin
        ben_r <= branch_taken(mask_r, bus.i_NZP);
      end
      if (err_set_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign bus.o_Instr_Ready = (state_r == ST_IDLE);
  assign bus.o_CC_Pending  = (state_r == ST_WAIT_WB);
  assign bus.o_LD_CC       = ld_cc_s;
  assign bus.o_BEN         = ben_r;
  assign bus.o_BEN_Valid   = ben_valid_r;
  assign bus.o_Timeout_Err = err_r;

endmodule
